// File: rtl/dino_pkg.sv
// Shared types and defaults for the dino jump/gravity controller.
package dino_pkg;

    typedef enum logic [1:0] {
        GROUND  = 2'd0,
        ASCEND  = 2'd1,
        DESCEND = 2'd2
    } dino_state_e;

    localparam int unsigned DEF_TICK_DIV = 250000;
    localparam int unsigned DEF_V0       = 12;
    localparam int unsigned DEF_Y_W      = 10;
    localparam int unsigned VEL_W        = 6;

    // Apex of a jump launched at v0: v0 + (v0-1) + ... + 1.
    function automatic int unsigned peak_height(input int unsigned v0);
        return (v0 * (v0 + 1)) / 2;
    endfunction

endpackage

// File: rtl/dino_motion_if.sv
// Controller-side signal bundle for dino_motion: jump/freeze in, height and status out.
interface dino_motion_if import dino_pkg::*; #(
    parameter int unsigned Y_W = DEF_Y_W
);
    logic           jump;
    logic           freeze;
    logic [Y_W-1:0] dino_y;
    logic           airborne;
    logic           landed;

    modport master (
        output jump, freeze,
        input  dino_y, airborne, landed
    );

    modport slave (
        input  jump, freeze,
        output dino_y, airborne, landed
    );
endinterface

// File: rtl/dino_motion_tick_gen.sv
// Physics tick divider: counts 0..DIV-1 while enabled, holds when disabled.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (en) begin
            if (count_q == LAST) begin
                tick    = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
endmodule

// File: rtl/dino_motion.sv
// Dino vertical motion: edge-triggered jump, per-tick constant-deceleration ascent
// and accelerating descent, with freeze and one-cycle touchdown pulse.
module dino_motion import dino_pkg::*; #(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned V0       = DEF_V0,
    parameter int unsigned Y_W      = DEF_Y_W
) (
    input logic          clk,
    input logic          rst,
    dino_motion_if.slave dif
);
    dino_state_e     state_q, state_d;
    logic [Y_W-1:0]   dino_y_q, dino_y_d;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic [VEL_W-1:0] fall_q, fall_d;
    logic             jump_prev_q, jump_prev_d;
    logic             armed_q, armed_d;
    logic             airborne_q, airborne_d;
    logic             landed_q, landed_d;
    logic             jump_edge;
    logic             tick;
    logic             tick_en;

    // The counter always wraps to 0 on the landing tick and is held in GROUND,
    // so it is already cleared whenever a new jump starts.
    assign tick_en = (state_q != GROUND) && !dif.freeze;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .tick(tick)
    );

    // armed_q only sets once jump has been seen low, so a level held through reset cannot launch.
    assign jump_prev_d = dif.jump;
    assign armed_d     = armed_q | ~dif.jump;
    assign jump_edge   = dif.jump & ~jump_prev_q & armed_q;

    always_comb begin
        state_d  = state_q;
        dino_y_d = dino_y_q;
        vel_d    = vel_q;
        fall_d   = fall_q;
        landed_d = 1'b0;
        if (!dif.freeze) begin
            unique case (state_q)
                GROUND: begin
                    if (jump_edge) begin
                        state_d = ASCEND;
                        vel_d   = VEL_W'(V0);
                    end
                end
                ASCEND: begin
                    if (tick) begin
                        dino_y_d = dino_y_q + Y_W'(vel_q);
                        if (vel_q == VEL_W'(1)) begin
                            state_d = DESCEND;
                            vel_d   = '0;
                            fall_d  = VEL_W'(1);
                        end else begin
                            vel_d = vel_q - VEL_W'(1);
                        end
                    end
                end
                DESCEND: begin
                    if (tick) begin
                        if (dino_y_q <= Y_W'(fall_q)) begin
                            dino_y_d = '0;
                            fall_d   = '0;
                            state_d  = GROUND;
                            landed_d = 1'b1;
                        end else begin
                            dino_y_d = dino_y_q - Y_W'(fall_q);
                            fall_d   = fall_q + VEL_W'(1);
                        end
                    end
                end
                default: state_d = GROUND;
            endcase
        end
        airborne_d = (state_d != GROUND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= GROUND;
            dino_y_q    <= '0;
            vel_q       <= '0;
            fall_q      <= '0;
            jump_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            airborne_q  <= 1'b0;
            landed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dino_y_q    <= dino_y_d;
            vel_q       <= vel_d;
            fall_q      <= fall_d;
            jump_prev_q <= jump_prev_d;
            armed_q     <= armed_d;
            airborne_q  <= airborne_d;
            landed_q    <= landed_d;
        end
    end

    assign dif.dino_y   = dino_y_q;
    assign dif.airborne = airborne_q;
    assign dif.landed   = landed_q;
endmodule

// File: tb/tb_dino_motion.sv
// Directed bench for dino_motion with TICK_DIV=4, V0=12: one physics tick every 4 clocks.
module tb_dino_motion;
    import dino_pkg::*;

    localparam int unsigned TD = 4;
    localparam int unsigned VZ = 12;
    localparam int unsigned YW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dino_motion_if #(.Y_W(YW)) dif ();

    dino_motion #(.TICK_DIV(TD), .V0(VZ), .Y_W(YW)) dut (
        .clk(clk),
        .rst(rst),
        .dif(dif)
    );

    int checks = 0;
    int errors = 0;

    int asc[12] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78};
    int dsc[12] = '{77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        dif.jump = 1'b0; dif.freeze = 1'b0; rst = 1'b1;
        #1;
        checks++; if (dif.dino_y !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", dif.dino_y); end
        checks++; if (dif.airborne !== 1'b0) begin errors++; $display("FAIL reset_airborne: got %0b expected 0", dif.airborne); end
        checks++; if (dif.landed !== 1'b0) begin errors++; $display("FAIL reset_landed: got %0b expected 0", dif.landed); end
        step(2); rst = 1'b0; step(2);
        checks++; if (dif.airborne !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %0b expected 0", dif.airborne); end
    endtask

    task automatic test_ascent;
        dif.jump = 1'b1; step(1);
        checks++; if (dif.airborne !== 1'b1) begin errors++; $display("FAIL launch_airborne: got %0b expected 1", dif.airborne); end
        checks++; if (dif.dino_y !== 10'd0) begin errors++; $display("FAIL launch_y: got %0d expected 0", dif.dino_y); end
        dif.jump = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(TD);
            checks++; if (dif.dino_y !== 10'(asc[k])) begin errors++; $display("FAIL ascent_tick%0d: got %0d expected %0d", k + 1, dif.dino_y, asc[k]); end
        end
        checks++; if (dif.airborne !== 1'b1) begin errors++; $display("FAIL peak_airborne: got %0b expected 1", dif.airborne); end
    endtask

    task automatic test_descent;
        for (int k = 0; k < 12; k++) begin
            step(TD);
            checks++; if (dif.dino_y !== 10'(dsc[k])) begin errors++; $display("FAIL descent_tick%0d: got %0d expected %0d", k + 13, dif.dino_y, dsc[k]); end
            checks++; if (dif.landed !== (k == 11)) begin errors++; $display("FAIL landed_tick%0d: got %0b expected %0b", k + 13, dif.landed, (k == 11)); end
        end
        checks++; if (dif.airborne !== 1'b0) begin errors++; $display("FAIL land_airborne: got %0b expected 0", dif.airborne); end
        step(1);
        checks++; if (dif.landed !== 1'b0) begin errors++; $display("FAIL landed_width: got %0b expected 0", dif.landed); end
    endtask

    task automatic test_hold_jump;
        int jumps = 0;
        int lands = 0;
        logic prev_air = 1'b0;
        dif.jump = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (dif.airborne && !prev_air) jumps++;
            if (dif.landed) lands++;
            prev_air = dif.airborne;
        end
        checks++; if (jumps !== 1) begin errors++; $display("FAIL held_jump_count: got %0d expected 1", jumps); end
        checks++; if (lands !== 1) begin errors++; $display("FAIL held_land_count: got %0d expected 1", lands); end
        dif.jump = 1'b0; step(2);
    endtask

    // 45 is not a height the V0=12 trajectory passes through; 42 (tick 4) is used instead.
    task automatic test_freeze;
        int n = 0;
        dif.jump = 1'b1; step(1); dif.jump = 1'b0;
        step(4 * TD);
        checks++; if (dif.dino_y !== 10'd42) begin errors++; $display("FAIL pre_freeze_y: got %0d expected 42", dif.dino_y); end
        step(2);
        dif.freeze = 1'b1; step(100);
        checks++; if (dif.dino_y !== 10'd42) begin errors++; $display("FAIL frozen_y: got %0d expected 42", dif.dino_y); end
        checks++; if (dif.airborne !== 1'b1) begin errors++; $display("FAIL frozen_airborne: got %0b expected 1", dif.airborne); end
        dif.freeze = 1'b0; step(1);
        checks++; if (dif.dino_y !== 10'd42) begin errors++; $display("FAIL resume_phase_early: got %0d expected 42", dif.dino_y); end
        step(1);
        checks++; if (dif.dino_y !== 10'd50) begin errors++; $display("FAIL resume_phase_tick: got %0d expected 50", dif.dino_y); end
        while (n < 200 && dif.landed !== 1'b1) begin step(1); n++; end
        checks++; if (n !== 76) begin errors++; $display("FAIL freeze_land_cycles: got %0d expected 76", n); end
        checks++; if (dif.dino_y !== 10'd0) begin errors++; $display("FAIL freeze_land_y: got %0d expected 0", dif.dino_y); end
        step(2);
    endtask

    task automatic test_reset_midair;
        logic bad_land = 1'b0;
        logic bad_air = 1'b0;
        dif.jump = 1'b1; step(1); dif.jump = 1'b0;
        step(12 * TD);
        checks++; if (dif.dino_y !== 10'd78) begin errors++; $display("FAIL peak_y: got %0d expected 78", dif.dino_y); end
        dif.jump = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (dif.dino_y !== 10'd0) begin errors++; $display("FAIL async_reset_y: got %0d expected 0", dif.dino_y); end
        checks++; if (dif.airborne !== 1'b0) begin errors++; $display("FAIL async_reset_air: got %0b expected 0", dif.airborne); end
        for (int i = 0; i < 3; i++) begin step(1); if (dif.landed !== 1'b0) bad_land = 1'b1; end
        checks++; if (bad_land !== 1'b0) begin errors++; $display("FAIL reset_no_landed: got %0b expected 0", bad_land); end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin step(1); if (dif.airborne !== 1'b0) bad_air = 1'b1; end
        checks++; if (bad_air !== 1'b0) begin errors++; $display("FAIL held_through_reset: got %0b expected 0", bad_air); end
        dif.jump = 1'b0; step(2);
        dif.jump = 1'b1; step(1);
        checks++; if (dif.airborne !== 1'b1) begin errors++; $display("FAIL rearm_jump: got %0b expected 1", dif.airborne); end
        dif.jump = 1'b0;
        step(24 * TD);
        checks++; if (dif.landed !== 1'b1) begin errors++; $display("FAIL rearm_land: got %0b expected 1", dif.landed); end
        step(2);
    endtask

    task automatic test_ignored_edges;
        dif.freeze = 1'b1; step(1);
        dif.jump = 1'b1; step(2); dif.jump = 1'b0; step(2);
        dif.freeze = 1'b0; step(10);
        checks++; if (dif.airborne !== 1'b0) begin errors++; $display("FAIL frozen_jump_air: got %0b expected 0", dif.airborne); end
        checks++; if (dif.dino_y !== 10'd0) begin errors++; $display("FAIL frozen_jump_y: got %0d expected 0", dif.dino_y); end
        dif.jump = 1'b1; step(1);
        checks++; if (dif.airborne !== 1'b1) begin errors++; $display("FAIL rejump_air: got %0b expected 1", dif.airborne); end
        dif.jump = 1'b0;
        step(2 * TD);
        checks++; if (dif.dino_y !== 10'd23) begin errors++; $display("FAIL rejump_tick2: got %0d expected 23", dif.dino_y); end
        dif.jump = 1'b1; step(2); dif.jump = 1'b0;
        step(10 * TD - 2);
        checks++; if (dif.dino_y !== 10'd78) begin errors++; $display("FAIL double_jump_peak: got %0d expected 78", dif.dino_y); end
        step(12 * TD);
        checks++; if (dif.dino_y !== 10'd0) begin errors++; $display("FAIL double_jump_land_y: got %0d expected 0", dif.dino_y); end
        checks++; if (dif.landed !== 1'b1) begin errors++; $display("FAIL double_jump_landed: got %0b expected 1", dif.landed); end
    endtask

    initial begin
        dif.jump   = 1'b0;
        dif.freeze = 1'b0;
        test_reset();
        test_ascent();
        test_descent();
        test_hold_jump();
        test_freeze();
        test_reset_midair();
        test_ignored_edges();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
